multi_cycle_control: RTL and testbench

//  Sequencer for the multi-cycle MIPS datapath. It steps each instruction through IF/ID/EXE/MEM/WB states.
//  In each state it drives the datapath enables and selects: PC, IR, register file, ALU, data memory, and ExtSel of the immediate extender.
//  It sits between the IR opcode field and the shared datapath resources, so one ALU and one memory port serve all phases.

---
 rtl/multi_cycle_control.sv | 164 ++++++++++++++++
 tb/tb_multi_cycle_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Control sequencer for a multi-cycle MIPS datapath: walks each instruction through
// IF/ID/EXE/MEM/WB and drives the shared-datapath enables, selects and a retired-instruction count.
module multi_cycle_control #(
  parameter int          RET_W   = 32,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic [2:0]       state,
  output logic             PCWre,
  output logic             IRWre,
  output logic [1:0]       PCSrc,
  output logic             ExtSel,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             RegDst,
  output logic             RegWre,
  output logic             DBDataSrc,
  output logic             mRD,
  output logic             mWR,
  output logic [RET_W-1:0] retired
);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b010000;
  localparam logic [5:0] OP_OR   = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [2:0]       state_q, state_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic is_add, is_sub, is_and, is_or, is_slt;
  logic is_addi, is_ori, is_sw, is_lw, is_beq, is_j, is_halt;
  logic is_rtype, is_nop;

  always_comb begin
    is_add   = (opcode == OP_ADD);
    is_sub   = (opcode == OP_SUB);
    is_and   = (opcode == OP_AND);
    is_or    = (opcode == OP_OR);
    is_slt   = (opcode == OP_SLT);
    is_addi  = (opcode == OP_ADDI);
    is_ori   = (opcode == OP_ORI);
    is_sw    = (opcode == OP_SW);
    is_lw    = (opcode == OP_LW);
    is_beq   = (opcode == OP_BEQ);
    is_j     = (opcode == OP_J);
    is_halt  = (opcode == HALT_OP);
    is_rtype = is_add | is_sub | is_and | is_or | is_slt;
    // Anything not decoded retires as a two-cycle no-op.
    is_nop   = ~(is_rtype | is_addi | is_ori | is_sw | is_lw | is_beq | is_j | is_halt);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID: begin
        if (is_halt)             state_d = S_HALT;
        else if (is_j || is_nop) state_d = S_IF;
        else                     state_d = S_EXE;
      end
      S_EXE: begin
        if (is_beq)              state_d = S_IF;
        else if (is_sw || is_lw) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM:  state_d = is_lw ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    ExtSel    = ~is_ori;
    ALUSrcB   = is_addi | is_ori | is_sw | is_lw;
    RegDst    = is_rtype;
    DBDataSrc = is_lw;
    if (is_sub || is_beq)     ALUOp = ALU_SUB;
    else if (is_and)          ALUOp = ALU_AND;
    else if (is_or || is_ori) ALUOp = ALU_OR;
    else if (is_slt)          ALUOp = ALU_SLT;
    else                      ALUOp = ALU_ADD;

    // Enables stay low while Reset is held so an aborted instruction writes nothing.
    if (!Reset) begin
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          PCWre = is_j | is_nop;
          if (is_j) PCSrc = 2'b10;
        end
        S_EXE: begin
          PCWre = is_beq;
          if (is_beq && zero) PCSrc = 2'b01;
        end
        S_MEM: begin
          PCWre = is_sw;
          mRD   = is_lw;
          mWR   = is_sw;
        end
        S_WB: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (PCWre) retired_d = retired_q + {{(RET_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: steps each opcode class through its states and
// checks every control output against hand-written vectors, plus reset abort and counter wrap.
module tb_multi_cycle_control;

  localparam int RET_W = 4;

  logic             CLK, Reset, zero;
  logic [5:0]       opcode;
  logic [2:0]       state;
  logic             PCWre, IRWre, ExtSel, ALUSrcB, RegDst, RegWre, DBDataSrc, mRD, mWR;
  logic [1:0]       PCSrc;
  logic [2:0]       ALUOp;
  logic [RET_W-1:0] retired;

  int n_assert = 0;
  int n_fail   = 0;
  logic [RET_W-1:0] exp_ret;

  multi_cycle_control #(.RET_W(RET_W), .HALT_OP(6'b111111)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .retired(retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Field order: state, PCWre, IRWre, PCSrc, ExtSel, ALUSrcB, ALUOp, RegDst, RegWre, DBDataSrc, mRD, mWR
  function automatic logic [16:0] pk(input logic [2:0] st, input logic pcw, input logic irw,
                                     input logic [1:0] src, input logic ext, input logic alub,
                                     input logic [2:0] op, input logic rd, input logic rw,
                                     input logic dbs, input logic mr, input logic mw);
    return {st, pcw, irw, src, ext, alub, op, rd, rw, dbs, mr, mw};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [16:0] exp);
    chk(tag, {15'd0, state, PCWre, IRWre, PCSrc, ExtSel, ALUSrcB, ALUOp,
              RegDst, RegWre, DBDataSrc, mRD, mWR}, {15'd0, exp});
    $display("step %-12s state=%b ctl=%h retired=%0d", tag, state,
             {PCWre, IRWre, PCSrc, ExtSel, ALUSrcB, ALUOp, RegDst, RegWre, DBDataSrc, mRD, mWR},
             retired);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [5:0] op, input logic z);
    opcode = op;
    zero   = z;
    #1;
  endtask

  task automatic run_j(input string tag);
    start(6'b111000, 1'b0);
    chk_ctl({tag, "_if"}, pk(3'b000, 0, 1, 2'b00, 1, 0, 3'b000, 0, 0, 0, 0, 0));
    step();
    chk_ctl({tag, "_id"}, pk(3'b001, 1, 0, 2'b10, 1, 0, 3'b000, 0, 0, 0, 0, 0));
    step();
    exp_ret = exp_ret + 1'b1;
    chk({tag, "_ret"}, {28'd0, retired}, {28'd0, exp_ret});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; opcode = 6'b000000; zero = 1'b0;
    exp_ret = '0;
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_ret", {28'd0, retired}, 32'd0);
    chk("rst_en", {27'd0, PCWre, IRWre, RegWre, mRD, mWR}, 32'd0);
    step();
    chk("rst_hold", {29'd0, state}, 32'd0);
    Reset = 1'b0;

    // add: IF ID EXE WB
    start(6'b000000, 1'b0);
    chk_ctl("add_if",  pk(3'b000, 0, 1, 2'b00, 1, 0, 3'b000, 1, 0, 0, 0, 0));
    step(); chk_ctl("add_id",  pk(3'b001, 0, 0, 2'b00, 1, 0, 3'b000, 1, 0, 0, 0, 0));
    step(); chk_ctl("add_exe", pk(3'b010, 0, 0, 2'b00, 1, 0, 3'b000, 1, 0, 0, 0, 0));
    step(); chk_ctl("add_wb",  pk(3'b100, 1, 0, 2'b00, 1, 0, 3'b000, 1, 1, 0, 0, 0));
    chk("add_ret_pre", {28'd0, retired}, 32'd0);
    step(); chk("add_ret", {28'd0, retired}, 32'd1);
    chk("add_back_if", {29'd0, state}, 32'd0);

    // Reset asserted mid-EXE of add aborts with no writes and clears retired
    start(6'b000000, 1'b0);
    step(); step();
    chk("abort_exe", {29'd0, state}, 32'd2);
    Reset = 1'b1; #1;
    chk_ctl("abort_rst", pk(3'b000, 0, 0, 2'b00, 1, 0, 3'b000, 1, 0, 0, 0, 0));
    chk("abort_ret", {28'd0, retired}, 32'd0);
    step();
    chk_ctl("abort_hold", pk(3'b000, 0, 0, 2'b00, 1, 0, 3'b000, 1, 0, 0, 0, 0));
    Reset = 1'b0;
    exp_ret = '0;

    // lw: IF ID EXE MEM WB
    start(6'b110001, 1'b0);
    chk_ctl("lw_if",  pk(3'b000, 0, 1, 2'b00, 1, 1, 3'b000, 0, 0, 1, 0, 0));
    step(); chk_ctl("lw_id",  pk(3'b001, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 1, 0, 0));
    step(); chk_ctl("lw_exe", pk(3'b010, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 1, 0, 0));
    step(); chk_ctl("lw_mem", pk(3'b011, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 1, 1, 0));
    step(); chk_ctl("lw_wb",  pk(3'b100, 1, 0, 2'b00, 1, 1, 3'b000, 0, 1, 1, 0, 0));
    step(); exp_ret = exp_ret + 1'b1;
    chk("lw_ret", {28'd0, retired}, {28'd0, exp_ret});

    // beq taken and not taken
    start(6'b110100, 1'b1);
    chk_ctl("beq1_if",  pk(3'b000, 0, 1, 2'b00, 1, 0, 3'b001, 0, 0, 0, 0, 0));
    step(); chk_ctl("beq1_id",  pk(3'b001, 0, 0, 2'b00, 1, 0, 3'b001, 0, 0, 0, 0, 0));
    step(); chk_ctl("beq1_exe", pk(3'b010, 1, 0, 2'b01, 1, 0, 3'b001, 0, 0, 0, 0, 0));
    step(); exp_ret = exp_ret + 1'b1;
    chk("beq1_ret", {28'd0, retired}, {28'd0, exp_ret});
    chk("beq1_back", {29'd0, state}, 32'd0);
    start(6'b110100, 1'b0);
    step(); step(); chk_ctl("beq0_exe", pk(3'b010, 1, 0, 2'b00, 1, 0, 3'b001, 0, 0, 0, 0, 0));
    step(); exp_ret = exp_ret + 1'b1;
    chk("beq0_ret", {28'd0, retired}, {28'd0, exp_ret});

    // ori: zero-extend, OR
    start(6'b010010, 1'b0);
    step(); chk_ctl("ori_id", pk(3'b001, 0, 0, 2'b00, 0, 1, 3'b011, 0, 0, 0, 0, 0));
    step(); chk_ctl("ori_exe", pk(3'b010, 0, 0, 2'b00, 0, 1, 3'b011, 0, 0, 0, 0, 0));
    step(); chk_ctl("ori_wb", pk(3'b100, 1, 0, 2'b00, 0, 1, 3'b011, 0, 1, 0, 0, 0));
    step(); exp_ret = exp_ret + 1'b1;

    // slt and sub: R-type with their ALU ops
    start(6'b100110, 1'b0);
    step(); step(); chk_ctl("slt_exe", pk(3'b010, 0, 0, 2'b00, 1, 0, 3'b100, 1, 0, 0, 0, 0));
    step(); chk_ctl("slt_wb", pk(3'b100, 1, 0, 2'b00, 1, 0, 3'b100, 1, 1, 0, 0, 0));
    step(); exp_ret = exp_ret + 1'b1;
    start(6'b000001, 1'b0);
    step(); chk_ctl("sub_id", pk(3'b001, 0, 0, 2'b00, 1, 0, 3'b001, 1, 0, 0, 0, 0));
    step(); step(); step(); exp_ret = exp_ret + 1'b1;
    chk("sub_ret", {28'd0, retired}, {28'd0, exp_ret});

    // j and an undefined opcode (nop) both retire in ID
    run_j("j0");
    start(6'b000111, 1'b0);
    step(); chk_ctl("nop_id", pk(3'b001, 1, 0, 2'b00, 1, 0, 3'b000, 0, 0, 0, 0, 0));
    step(); exp_ret = exp_ret + 1'b1;
    chk("nop_ret", {28'd0, retired}, {28'd0, exp_ret});
    chk("nop_back", {29'd0, state}, 32'd0);

    // fill the 4-bit counter to all ones, then sw wraps it to zero
    for (int i = 0; i < 7; i++) run_j($sformatf("jf%0d", i));
    chk("ret_full", {28'd0, retired}, 32'd15);
    start(6'b110000, 1'b0);
    chk_ctl("sw_if",  pk(3'b000, 0, 1, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0, 0));
    step(); step(); chk_ctl("sw_exe", pk(3'b010, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0, 0));
    step(); chk_ctl("sw_mem", pk(3'b011, 1, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0, 1));
    step(); chk("sw_wrap", {28'd0, retired}, 32'd0);
    chk("sw_back", {29'd0, state}, 32'd0);

    // HALT: sticks, no PC writes
    start(6'b111111, 1'b0);
    step(); chk_ctl("halt_id", pk(3'b001, 0, 0, 2'b00, 1, 0, 3'b000, 0, 0, 0, 0, 0));
    step(); chk_ctl("halt_st", pk(3'b111, 0, 0, 2'b00, 1, 0, 3'b000, 0, 0, 0, 0, 0));
    opcode = 6'b111000; #1;
    step(); step(); step();
    chk_ctl("halt_stuck", pk(3'b111, 0, 0, 2'b00, 1, 0, 3'b000, 0, 0, 0, 0, 0));
    chk("halt_ret", {28'd0, retired}, 32'd0);
    Reset = 1'b1; #1;
    chk("halt_rst", {29'd0, state}, 32'd0);
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
